memref_rd_arbiter: RTL and testbench
====================================

Name: memref_rd_arbiter

Overview:
Shares one read port of a single-ported memref (the memref_rd model or a BRAM) among NUM_REQ requesters. Each requester holds a request until it is granted.
- Grant order is round-robin.
- The block tags every issued read and routes the returned data-valid back to the originating requester after the fixed memory read latency.
- Sits between compute kernels (e.g. kernelX/kernelY coefficient loaders, or the HIR and HLS unsharp-mask instances in a shared bench) and a single memref_rd instance.

Parameters:
NUM_REQ, 2, number of requesters (2..8)
ADDR_WIDTH, 10, memref address width
DATA_WIDTH, 32, memref data width
RD_LATENCY, 1, cycles from mem_rd_en to valid mem_rd_data (1..4)

Ports:
clk  input  1  clock, all state on rising edge
rst  input  1  asynchronous, active-high reset
req_rd_en  input  NUM_REQ  per-requester read request, held until granted
req_addr_data  input  NUM_REQ*ADDR_WIDTH  packed addresses, requester i at bits [i*ADDR_WIDTH +: ADDR_WIDTH]
req_gnt  output  NUM_REQ  one-hot grant, combinational, same cycle as the issued read
req_rd_valid  output  NUM_REQ  one-hot, data on req_rd_data belongs to this requester
req_rd_data  output  DATA_WIDTH  broadcast read data (= mem_rd_data)
mem_rd_en  output  1  read enable to memref
mem_addr_data  output  ADDR_WIDTH  address to memref
mem_rd_data  input  DATA_WIDTH  read data from memref

Behaviour:
- State:
  - rr_ptr (clog2(NUM_REQ) bits): requester with highest priority this cycle.
  - Tag pipeline of RD_LATENCY stages, each {vld, id}.
- Arbitration (combinational):
  - Winner is the first i with req_rd_en[i]=1, scanning rr_ptr, rr_ptr+1, ... mod NUM_REQ.
  - req_gnt = onehot(winner), or 0 if there is no request.
  - mem_rd_en = |req_rd_en.
  - mem_addr_data = address of the winner, 0 when idle.
- rr_ptr update:
  - After a grant to i: rr_ptr <= (i+1) mod NUM_REQ (wraps from NUM_REQ-1 to 0).
  - No grant: rr_ptr unchanged.
- Handshake:
  - A request is consumed in the cycle req_gnt[i]=1.
  - A requester that keeps req_rd_en high in the next cycle issues a new read.
  - Address must stay stable while the request is pending and ungranted.
  - No back-pressure on the return path; requesters must accept data when valid.
- Return path:
  - Stage0 <= {mem_rd_en, winner}; stage k <= stage k-1.
  - req_rd_valid = onehot(last.id) when last.vld, else 0.
  - Read for grant at cycle T appears at cycle T+RD_LATENCY.
  - One read in flight per cycle; full throughput of one read per cycle.
- Reset values:
  - rr_ptr=0 and all tag stages vld=0.
  - Consequently req_rd_valid=0; mem_rd_en=0 and req_gnt=0 when no requests.
- Boundary conditions:
  - Single requester continuously asserting: granted every cycle.
  - All requesters asserting: strict rotation 0,1,...,NUM_REQ-1,0.
  - Reset mid-operation: in-flight tags discarded, so no req_rd_valid for reads issued before rst deassertion; rr_ptr returns to 0.
  - Request rising in the same cycle rr_ptr points at it: granted that cycle.

Optional Feature:
MEMREF_ARB_STATS_EN
- Defined: adds outputs stat_grant_cnt (NUM_REQ*32, per-requester grant count) and stat_conflict_cnt (32, cycles with >=2 requests asserted).
  - Counters saturate at 2^32-1 and are cleared by rst.
  - Counter values are registered, updated the cycle after the event.
- Undefined: these ports and counters do not exist; arbitration behaviour is identical.

Test Plan:
- Memory init mem[a]=a+100, RD_LATENCY=1; req0 only, addr 5, held 3 cycles -> gnt0 each cycle; req_rd_data=105 with req_rd_valid=01 one cycle after each grant.
- req0 addr 2 and req1 addr 3 held simultaneously from reset -> grants 0,1,0,1; valid sequence 01/102, 10/103, 01/102, 10/103.
- NUM_REQ=3, all requesting; req2 drops after first grant -> grant order 0,1,2,0,1,0,1; rr_ptr wraps 2->0.
- RD_LATENCY=3, req1 addr 7 granted at cycle 10 -> req_rd_valid=10, data 107 at cycle 13; no other valid cycles.
- rst pulsed the cycle after a grant with RD_LATENCY=2 -> no req_rd_valid for that read; after rst, first simultaneous grant goes to requester 0.
- STATS_EN: 4 cycles of both requesting, then 2 cycles of req0 only -> stat_grant_cnt = {2 (req1), 4 (req0)}, stat_conflict_cnt = 4.

Source files
------------

// File: rtl/memref_rd_arbiter.sv
// memref_rd_arbiter
//   Shares the single read port of a memref (memref_rd model or BRAM) among
//   NUM_REQ requesters. The arbiter is round-robin and grants in the same
//   cycle as the request. Every issued read carries a tag that travels down
//   an RD_LATENCY-deep pipeline, so the returned data-valid reaches the
//   requester that issued the read.
//
// Ports
//   clk, rst          clock (rising edge), asynchronous active-high reset
//   req_rd_en         per-requester read request, held until granted
//   req_addr_data     packed addresses, requester i at [i*ADDR_WIDTH +: ADDR_WIDTH]
//   req_gnt           one-hot grant, combinational, same cycle as the read
//   req_rd_valid      one-hot owner of the data currently on req_rd_data
//   req_rd_data       broadcast read data (mem_rd_data passed through)
//   mem_rd_en         read enable to the memref
//   mem_addr_data     address to the memref (0 when idle)
//   mem_rd_data       read data from the memref
//
// Optional build macro
//   MEMREF_ARB_STATS_EN  adds stat_grant_cnt (32 bits per requester) and
//                        stat_conflict_cnt (cycles with >= 2 requests).
//                        Both counters saturate and are registered.

module memref_rd_arbiter #(
  parameter int NUM_REQ    = 2,
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 32,
  parameter int RD_LATENCY = 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req_rd_en,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr_data,
  output logic [NUM_REQ-1:0]            req_gnt,
  output logic [NUM_REQ-1:0]            req_rd_valid,
  output logic [DATA_WIDTH-1:0]         req_rd_data,
  output logic                          mem_rd_en,
  output logic [ADDR_WIDTH-1:0]         mem_addr_data,
`ifdef MEMREF_ARB_STATS_EN
  output logic [NUM_REQ*32-1:0]         stat_grant_cnt,
  output logic [31:0]                   stat_conflict_cnt,
`endif
  input  logic [DATA_WIDTH-1:0]         mem_rd_data
);

  localparam int              ID_W      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [ID_W:0]   NUM_REQ_X = (ID_W+1)'(NUM_REQ);
  localparam logic [ID_W-1:0] LAST_ID   = ID_W'(NUM_REQ - 1);

  logic [ID_W-1:0]       rr_ptr;
  logic                  found;
  logic [ID_W-1:0]       winner;
  logic [ID_W:0]         scan_idx;

  logic [RD_LATENCY-1:0] tag_vld;
  logic [ID_W-1:0]       tag_id [RD_LATENCY];

  // Scan starting at rr_ptr; the one extra bit in scan_idx lets the modulo
  // be a single conditional subtract.
  always_comb begin
    found    = 1'b0;
    winner   = '0;
    scan_idx = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      scan_idx = {1'b0, rr_ptr} + (ID_W+1)'(k);
      if (scan_idx >= NUM_REQ_X) scan_idx = scan_idx - NUM_REQ_X;
      if (!found && req_rd_en[scan_idx[ID_W-1:0]]) begin
        found  = 1'b1;
        winner = scan_idx[ID_W-1:0];
      end
    end
  end

  always_comb begin
    req_gnt       = '0;
    mem_addr_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (found && (winner == ID_W'(i))) begin
        req_gnt[i]    = 1'b1;
        mem_addr_data = req_addr_data[i*ADDR_WIDTH +: ADDR_WIDTH];
      end
    end
  end

  assign mem_rd_en = found;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr  <= '0;
      tag_vld <= '0;
      for (int k = 0; k < RD_LATENCY; k++) tag_id[k] <= '0;
    end else begin
      if (found) rr_ptr <= (winner == LAST_ID) ? '0 : winner + ID_W'(1);
      tag_vld[0] <= found;
      tag_id[0]  <= winner;
      for (int k = 1; k < RD_LATENCY; k++) begin
        tag_vld[k] <= tag_vld[k-1];
        tag_id[k]  <= tag_id[k-1];
      end
    end
  end

  always_comb begin
    req_rd_valid = '0;
    for (int i = 0; i < NUM_REQ; i++)
      req_rd_valid[i] = tag_vld[RD_LATENCY-1] && (tag_id[RD_LATENCY-1] == ID_W'(i));
  end

  assign req_rd_data = mem_rd_data;

`ifdef MEMREF_ARB_STATS_EN
  logic conflict;
  assign conflict = ($countones(req_rd_en) > 1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_grant_cnt    <= '0;
      stat_conflict_cnt <= '0;
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (req_gnt[i] && (stat_grant_cnt[i*32 +: 32] != 32'hFFFF_FFFF))
          stat_grant_cnt[i*32 +: 32] <= stat_grant_cnt[i*32 +: 32] + 32'd1;
      end
      if (conflict && (stat_conflict_cnt != 32'hFFFF_FFFF))
        stat_conflict_cnt <= stat_conflict_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_memref_rd_arbiter.sv
// Bench for memref_rd_arbiter: NUM_REQ=3, RD_LATENCY=3, memory mem[a]=a+100.
// Directed scenarios carry literal expectations; a cycle-level model checks
// grants, memory address and returned valid/data on every cycle.
module tb_memref_rd_arbiter;
  localparam int N  = 3;
  localparam int AW = 10;
  localparam int DW = 32;
  localparam int L  = 3;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [N-1:0]    req_rd_en = '0;
  logic [AW-1:0]   addr_a [N];
  logic [N*AW-1:0] req_addr_data;
  logic [N-1:0]    req_gnt;
  logic [N-1:0]    req_rd_valid;
  logic [DW-1:0]   req_rd_data;
  logic            mem_rd_en;
  logic [AW-1:0]   mem_addr_data;
  logic [DW-1:0]   mem_rd_data;
`ifdef MEMREF_ARB_STATS_EN
  logic [N*32-1:0] stat_grant_cnt;
  logic [31:0]     stat_conflict_cnt;
`endif

  assign req_addr_data = {addr_a[2], addr_a[1], addr_a[0]};

  always #5 clk = ~clk;

  memref_rd_arbiter #(
    .NUM_REQ(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RD_LATENCY(L)
  ) dut (
    .clk(clk),
    .rst(rst),
    .req_rd_en(req_rd_en),
    .req_addr_data(req_addr_data),
    .req_gnt(req_gnt),
    .req_rd_valid(req_rd_valid),
    .req_rd_data(req_rd_data),
    .mem_rd_en(mem_rd_en),
    .mem_addr_data(mem_addr_data),
`ifdef MEMREF_ARB_STATS_EN
    .stat_grant_cnt(stat_grant_cnt),
    .stat_conflict_cnt(stat_conflict_cnt),
`endif
    .mem_rd_data(mem_rd_data)
  );

  // Memory with fixed read latency L: mem[a] = a + 100.
  logic [AW-1:0] mem_pipe [L];
  always @(posedge clk) begin
    mem_pipe[0] <= mem_addr_data;
    for (int k = 1; k < L; k++) mem_pipe[k] <= mem_pipe[k-1];
  end
  assign mem_rd_data = 32'(mem_pipe[L-1]) + 32'd100;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: round-robin pointer as an integer, plus a history ring
  // of which requester/address was granted in each cycle.
  int            m_rr = 0;
  int            m_cyc = 0;
  logic          hv [16];
  int            hid [16];
  logic [AW-1:0] ha [16];
  int            w, idx, s;
  logic [N-1:0]  eg, ev;
  logic [AW-1:0] ea;
`ifdef MEMREF_ARB_STATS_EN
  int m_gcnt [N];
  int m_ccnt = 0;
`endif

  initial begin
    for (int k = 0; k < 16; k++) begin hv[k] = 1'b0; hid[k] = 0; ha[k] = '0; end
`ifdef MEMREF_ARB_STATS_EN
    for (int k = 0; k < N; k++) m_gcnt[k] = 0;
`endif
  end

  always @(negedge clk) begin
    if (rst) begin
      m_rr = 0;
      for (int k = 0; k < 16; k++) hv[k] = 1'b0;
`ifdef MEMREF_ARB_STATS_EN
      for (int k = 0; k < N; k++) m_gcnt[k] = 0;
      m_ccnt = 0;
`endif
    end
    w = -1;
    for (int k = 0; k < N; k++) begin
      idx = (m_rr + k) % N;
      if (w < 0 && req_rd_en[idx]) w = idx;
    end
    eg = '0;
    ea = '0;
    if (w >= 0) begin eg[w] = 1'b1; ea = addr_a[w]; end
    chk("model gnt", 32'(req_gnt), 32'(eg));
    chk("model mem_rd_en", 32'(mem_rd_en), 32'(req_rd_en != '0));
    chk("model mem_addr", 32'(mem_addr_data), 32'(ea));

    ev = '0;
    if (m_cyc >= L) begin
      s = (m_cyc - L) % 16;
      if (hv[s]) ev[hid[s]] = 1'b1;
    end
    chk("model rd_valid", 32'(req_rd_valid), 32'(ev));
    if (ev != '0) chk("model rd_data", req_rd_data, 32'(ha[s]) + 32'd100);

`ifdef MEMREF_ARB_STATS_EN
    for (int k = 0; k < N; k++)
      chk("model stat_grant", stat_grant_cnt[k*32 +: 32], 32'(m_gcnt[k]));
    chk("model stat_conflict", stat_conflict_cnt, 32'(m_ccnt));
    if (!rst) begin
      if (w >= 0) m_gcnt[w]++;
      if ($countones(req_rd_en) >= 2) m_ccnt++;
    end
`endif

    hv[m_cyc % 16]  = (w >= 0) && !rst;
    hid[m_cyc % 16] = (w >= 0) ? w : 0;
    ha[m_cyc % 16]  = ea;
    if (!rst && w >= 0) m_rr = (w + 1) % N;
    m_cyc++;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req_rd_en = '0;
    step();
    step();
    rst = 1'b0;
  endtask

  logic [N-1:0]  eg_b [4] = '{3'b001, 3'b010, 3'b001, 3'b010};
  logic [31:0]   ed_b [4] = '{32'd102, 32'd103, 32'd102, 32'd103};
  logic [N-1:0]  eg_c [7] = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b001, 3'b010};
  logic [N-1:0]  last_g;
  int            pct;

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not complete, got running, expected finished");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < N; i++) addr_a[i] = '0;
    rst = 1'b1;
    req_rd_en = '0;
    @(negedge clk);
    chk("reset gnt", 32'(req_gnt), 32'd0);
    chk("reset rd_valid", 32'(req_rd_valid), 32'd0);
    chk("reset mem_rd_en", 32'(mem_rd_en), 32'd0);
    step();
    rst = 1'b0;

    // Single requester held 3 cycles: granted every cycle, data 105 after L.
    req_rd_en = 3'b001;
    addr_a[0] = 10'd5;
    for (int j = 0; j < 3; j++) begin
      @(negedge clk);
      chk("single gnt", 32'(req_gnt), 32'b001);
      step();
    end
    req_rd_en = '0;
    for (int j = 0; j < 3; j++) begin
      @(negedge clk);
      chk("single rd_valid", 32'(req_rd_valid), 32'b001);
      chk("single rd_data", req_rd_data, 32'd105);
      step();
    end
    @(negedge clk);
    chk("single drained", 32'(req_rd_valid), 32'd0);

    // Two requesters from reset: alternate, data routed to the owner.
    do_reset();
    req_rd_en = 3'b011;
    addr_a[0] = 10'd2;
    addr_a[1] = 10'd3;
    for (int j = 0; j < 7; j++) begin
      if (j == 4) req_rd_en = '0;
      @(negedge clk);
      if (j < 4) chk("pair gnt", 32'(req_gnt), 32'(eg_b[j]));
      if (j >= 3) begin
        chk("pair rd_valid", 32'(req_rd_valid), 32'(eg_b[j-3]));
        chk("pair rd_data", req_rd_data, ed_b[j-3]);
      end
      step();
    end

    // All three requesting, req2 drops after its grant: 0,1,2,0,1,0,1.
    do_reset();
    req_rd_en = 3'b111;
    addr_a[0] = 10'd10;
    addr_a[1] = 10'd11;
    addr_a[2] = 10'd12;
    for (int j = 0; j < 7; j++) begin
      if (j == 3) req_rd_en = 3'b011;
      @(negedge clk);
      chk("rotate gnt", 32'(req_gnt), 32'(eg_c[j]));
      step();
    end
    req_rd_en = '0;
    for (int j = 0; j < L + 1; j++) step();

    // Single read by requester 1: exactly one valid, L cycles later.
    do_reset();
    req_rd_en = 3'b010;
    addr_a[1] = 10'd7;
    for (int j = 0; j < 6; j++) begin
      if (j == 1) req_rd_en = '0;
      @(negedge clk);
      if (j == 0) chk("lat gnt", 32'(req_gnt), 32'b010);
      else chk("lat rd_valid", 32'(req_rd_valid), (j == L) ? 32'b010 : 32'd0);
      if (j == L) chk("lat rd_data", req_rd_data, 32'd107);
      step();
    end

    // Reset right after a grant: that read never returns, pointer back to 0.
    do_reset();
    req_rd_en = 3'b001;
    addr_a[0] = 10'd9;
    @(negedge clk);
    chk("rstmid gnt", 32'(req_gnt), 32'b001);
    step();
    rst = 1'b1;
    req_rd_en = '0;
    step();
    rst = 1'b0;
    req_rd_en = 3'b011;
    @(negedge clk);
    chk("rstmid first gnt", 32'(req_gnt), 32'b001);
    step();
    req_rd_en = '0;
    @(negedge clk);
    chk("rstmid lost read", 32'(req_rd_valid), 32'd0);
    for (int j = 0; j < L + 1; j++) step();

    // Random traffic: requests held until granted with a stable address.
    do_reset();
    for (int c = 0; c < 2400; c++) begin
      pct = 3 + 3 * ((c / 400) % 3);
      @(negedge clk);
      last_g = req_gnt;
      step();
      if ($urandom_range(0, 249) == 0) begin
        rst = 1'b1;
        req_rd_en = '0;
      end else begin
        rst = 1'b0;
        for (int i = 0; i < N; i++) begin
          if (!(req_rd_en[i] && !last_g[i])) begin
            req_rd_en[i] = ($urandom_range(0, 9) < pct);
            addr_a[i]    = AW'($urandom_range(0, 1023));
          end
        end
      end
    end
    rst = 1'b0;
    req_rd_en = '0;
    for (int j = 0; j < L + 3; j++) step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
